// File: rtl/sample_mem_reader.sv
// Sample memory read walker: issues synchronous reads over 0..DEPTH-1 (wrapping) and
// buffers returned words in a small prefetch FIFO for a valid/ready consumer.
//
// state | meaning
// IDLE  | not streaming; FIFO, in-flight pipe and next address held cleared
// RUN   | issuing reads while buffered + in-flight words stay below FIFO_DEPTH
module sample_mem_reader #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 62500,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_last,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              frame_done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [RD_LAT-1:0] vpipe, lpipe;
  logic [ADDR_W-1:0] next_addr;
  logic              pop, push, issue;
  int                outstanding;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign sample_valid = (count != '0);
  assign sample_data  = fifo_data[rd_ptr];
  assign sample_last  = sample_valid & fifo_last[rd_ptr];

  // Outstanding counts words buffered plus reads still travelling through memory.
  always_comb begin
    pop         = sample_valid & sample_ready;
    push        = vpipe[RD_LAT-1] & (state == RUN);
    outstanding = int'(count) + int'(mem_rd_en) + $countones(vpipe) - int'(pop);
    issue       = enable & (outstanding < FIFO_DEPTH);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      next_addr  <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      vpipe      <= '0;
      lpipe      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop & sample_last;
      if (!enable) begin
        state     <= IDLE;
        mem_rd_en <= 1'b0;
        next_addr <= '0;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        count     <= '0;
        vpipe     <= '0;
        lpipe     <= '0;
      end else begin
        state     <= RUN;
        mem_rd_en <= issue;
        if (issue) begin
          mem_addr  <= next_addr;
          next_addr <= (next_addr == LAST_ADDR) ? '0 : next_addr + 1'b1;
        end
        vpipe[0] <= mem_rd_en;
        lpipe[0] <= (mem_addr == LAST_ADDR);
        for (int i = 1; i < RD_LAT; i++) begin
          vpipe[i] <= vpipe[i-1];
          lpipe[i] <= lpipe[i-1];
        end
        if (push) begin
          fifo_data[wr_ptr] <= mem_rdata;
          fifo_last[wr_ptr] <= lpipe[RD_LAT-1];
          wr_ptr            <= ptr_inc(wr_ptr);
        end
        if (pop)
          rd_ptr <= ptr_inc(rd_ptr);
        if (push && !pop)
          count <= count + 1'b1;
        else if (pop && !push)
          count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sample_mem_reader.sv
// Bench for sample_mem_reader: instance a (RD_LAT=1, FIFO_DEPTH=4, full frame) and
// instance b (RD_LAT=3, FIFO_DEPTH=5, short frame) against a word-sequence scoreboard.
module tb_sample_mem_reader;

  localparam int DEPTH_A = 62500;
  localparam int DEPTH_B = 1000;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        en [2];
  logic        rd_en [2];
  logic [15:0] addr [2];
  logic [15:0] rdata [2];
  logic [15:0] data [2];
  logic        last [2];
  logic        valid [2];
  logic        ready [2];
  logic        fd [2];
  logic [15:0] p1, p2;

  int total = 0;
  int bad = 0;
  bit armed = 0;
  int exp_word [2] = '{0, 0};
  logic exp_fd [2] = '{1'b0, 1'b0};
  int issued [2] = '{0, 0};
  int popped [2] = '{0, 0};
  int pops [2] = '{0, 0};

  always #5 clk = ~clk;

  sample_mem_reader #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH_A), .RD_LAT(1), .FIFO_DEPTH(4)) u_a (
    .clock(clk), .reset_n(rst[0]), .enable(en[0]), .mem_rd_en(rd_en[0]), .mem_addr(addr[0]),
    .mem_rdata(rdata[0]), .sample_data(data[0]), .sample_last(last[0]), .sample_valid(valid[0]),
    .sample_ready(ready[0]), .frame_done(fd[0]));

  sample_mem_reader #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH_B), .RD_LAT(3), .FIFO_DEPTH(5)) u_b (
    .clock(clk), .reset_n(rst[1]), .enable(en[1]), .mem_rd_en(rd_en[1]), .mem_addr(addr[1]),
    .mem_rdata(rdata[1]), .sample_data(data[1]), .sample_last(last[1]), .sample_valid(valid[1]),
    .sample_ready(ready[1]), .frame_done(fd[1]));

  // Memory content is word = address; latency 1 for a, 3 for b.
  always @(posedge clk) begin
    rdata[0] <= addr[0];
    p1       <= addr[1];
    p2       <= p1;
    rdata[1] <= p2;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int dep(input int i);
    return (i == 0) ? DEPTH_A : DEPTH_B;
  endfunction

  function automatic int fdep(input int i);
    return (i == 0) ? 4 : 5;
  endfunction

  // Scoreboard: inputs are stable here, so valid&ready predicts the pop at the next edge.
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        chk(i == 0 ? "a_frame_done" : "b_frame_done", fd[i], exp_fd[i]);
        if (rd_en[i]) issued[i]++;
        chk(i == 0 ? "a_outstanding" : "b_outstanding",
            (issued[i] - popped[i] <= fdep(i)), 1);
        exp_fd[i] = 1'b0;
        if (!rst[i]) begin
          exp_word[i] = 0;
          issued[i] = 0;
          popped[i] = 0;
        end else begin
          if (valid[i] && ready[i]) begin
            chk(i == 0 ? "a_data" : "b_data", data[i], exp_word[i]);
            chk(i == 0 ? "a_last" : "b_last", last[i], exp_word[i] == dep(i) - 1);
            exp_fd[i] = (exp_word[i] == dep(i) - 1);
            exp_word[i] = (exp_word[i] + 1) % dep(i);
            popped[i]++;
            pops[i]++;
          end
          if (!en[i]) begin
            exp_word[i] = 0;
            issued[i] = 0;
            popped[i] = 0;
          end
        end
      end
    end
  end

  initial begin
    int n;
    int guard;
    int target;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; en[i] = 1'b0; ready[i] = 1'b0;
    end
    tick();
    armed = 1;
    tick();
    chk("rst_rd_en", rd_en[0], 0);
    chk("rst_addr", addr[0], 0);
    chk("rst_valid", valid[0], 0);
    chk("rst_last", last[0], 0);
    chk("rst_fd", fd[0], 0);
    chk("rst_b_valid", valid[1], 0);
    rst[0] = 1'b1; rst[1] = 1'b1;
    tick();

    // streaming from address 0 at full rate
    en[0] = 1'b1; ready[0] = 1'b1;
    tick();
    chk("t1_rd_en", rd_en[0], 1);
    chk("t1_addr0", addr[0], 0);
    chk("t1_valid_k", valid[0], 0);
    tick();
    chk("t1_addr1", addr[0], 1);
    chk("t1_valid_k1", valid[0], 0);
    tick();
    chk("t1_valid_k2", valid[0], 1);
    chk("t1_data0", data[0], 0);
    chk("t1_addr2", addr[0], 2);
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("t1_addr_seq", addr[0], 2 + j);
      chk("t1_data_seq", data[0], j);
    end

    // consumer stall then release
    en[0] = 1'b0; ready[0] = 1'b0;
    tick();
    chk("t2_flush_valid", valid[0], 0);
    en[0] = 1'b1;
    n = 0;
    for (int j = 0; j < 12; j++) begin
      tick();
      n += int'(rd_en[0]);
    end
    chk("t2_reads", n, 4);
    chk("t2_stall", rd_en[0], 0);
    chk("t2_head", data[0], 0);
    ready[0] = 1'b1;
    tick();
    chk("t2_resume", rd_en[0], 1);
    for (int j = 0; j < 6; j++) tick();

    // frame wrap
    guard = 0;
    while (!(rd_en[0] && addr[0] == 16'(DEPTH_A - 2)) && guard < 70000) begin
      tick();
      guard++;
    end
    chk("t3_reach", guard < 70000, 1);
    tick();
    chk("t3_addr_last", addr[0], DEPTH_A - 1);
    tick();
    chk("t3_addr_wrap", addr[0], 0);
    chk("t3_nogap", rd_en[0], 1);
    tick();
    chk("t3_addr_after", addr[0], 1);
    guard = 0;
    while (!(valid[0] && last[0]) && guard < 20) begin
      tick();
      guard++;
    end
    chk("t3_last_seen", guard < 20, 1);
    chk("t3_last_data", data[0], DEPTH_A - 1);
    tick();
    chk("t3_fd", fd[0], 1);
    tick();
    chk("t3_fd_once", fd[0], 0);

    // drop enable with 3 buffered and 2 in flight
    ready[1] = 1'b0; en[1] = 1'b1;
    tick();
    for (int j = 0; j < 6; j++) tick();
    chk("t4_buffered", valid[1], 1);
    chk("t4_head", data[1], 0);
    en[1] = 1'b0;
    tick();
    chk("t4_flushed", valid[1], 0);
    chk("t4_rd_off", rd_en[1], 0);
    for (int j = 0; j < 5; j++) tick();
    chk("t4_idle_valid", valid[1], 0);
    en[1] = 1'b1; ready[1] = 1'b1;
    tick();
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("t4_lat_valid", valid[1], 0);
    end
    tick();
    chk("t4_restart_valid", valid[1], 1);
    chk("t4_restart_data", data[1], 0);

    // random consumer over three frames
    target = pops[1] + 3 * DEPTH_B;
    guard = 0;
    while (pops[1] < target && guard < 20 * DEPTH_B) begin
      ready[1] = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    chk("t5_done", pops[1] >= target, 1);

    // mid-stream reset
    rst[0] = 1'b0;
    tick();
    chk("t6_rd_en", rd_en[0], 0);
    chk("t6_addr", addr[0], 0);
    chk("t6_valid", valid[0], 0);
    chk("t6_last", last[0], 0);
    chk("t6_fd", fd[0], 0);
    rst[0] = 1'b1;
    tick();
    chk("t6_rd_en_k", rd_en[0], 1);
    chk("t6_addr_k", addr[0], 0);
    tick();
    chk("t6_valid_k1", valid[0], 0);
    tick();
    chk("t6_valid_k2", valid[0], 1);
    chk("t6_data_k2", data[0], 0);
    for (int j = 0; j < 4; j++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
